// File: rtl/ram8_arbiter_if.sv
// ram8_arbiter_if: requester A/B handshakes, RAM8 port and status of the ram8_arbiter.
interface ram8_arbiter_if;
  logic        a_req, a_we, a_ack, b_req, b_we, b_ack, ram_load, busy;
  logic [2:0]  a_addr, b_addr, ram_address;
  logic [15:0] a_wdata, a_rdata, b_wdata, b_rdata, ram_in, ram_out;
  logic [15:0] grant_count_a, grant_count_b;
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_out,
    input  a_ack, a_rdata, b_ack, b_rdata, ram_address, ram_in, ram_load, busy,
           grant_count_a, grant_count_b
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_out,
    output a_ack, a_rdata, b_ack, b_rdata, ram_address, ram_in, ram_load, busy,
           grant_count_a, grant_count_b
  );
endinterface

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: two-requester arbiter/sequencer in front of one RAM8 (IDLE/SERVE/DONE).
// Grant counters exist only when RAM8_ARB_STATS_EN is defined; otherwise they read 0.
module ram8_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic           clk,
  input logic           reset,
  ram8_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  state_t      state;
  logic        win;
  logic        pick;
  logic        sel_we;
  logic [2:0]  addr_q;
  logic [15:0] in_q;
  // win doubles as last_winner: it holds the most recent grant (1 = B)
  always_comb begin
    pick   = (bus.a_req && bus.b_req) ? (FIXED_PRIO ? 1'b0 : ~win) : ~bus.a_req;
    sel_we = win ? bus.b_we : bus.a_we;
  end
  assign bus.ram_address = (state == SERVE) ? (win ? bus.b_addr : bus.a_addr) : addr_q;
  assign bus.ram_in      = (state == SERVE) ? (win ? bus.b_wdata : bus.a_wdata) : in_q;
  assign bus.ram_load    = (state == SERVE) && !reset && sel_we;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      win         <= 1'b1;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
      bus.busy    <= 1'b0;
      addr_q      <= '0;
      in_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          if (bus.a_req || bus.b_req) begin
            win      <= pick;
            state    <= SERVE;
            bus.busy <= 1'b1;
          end
        end
        SERVE: begin
          addr_q    <= bus.ram_address;
          in_q      <= bus.ram_in;
          if (!sel_we && !win) bus.a_rdata <= bus.ram_out;
          if (!sel_we && win) bus.b_rdata <= bus.ram_out;
          bus.a_ack <= ~win;
          bus.b_ack <= win;
          state     <= DONE;
        end
        DONE: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RAM8_ARB_STATS_EN
  logic grant;
  assign grant = (state == IDLE) && (bus.a_req || bus.b_req);
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.grant_count_a <= '0;
      bus.grant_count_b <= '0;
    end else begin
      if (grant && !pick && bus.grant_count_a != 16'hFFFF) bus.grant_count_a <= bus.grant_count_a + 16'd1;
      if (grant && pick && bus.grant_count_b != 16'hFFFF) bus.grant_count_b <= bus.grant_count_b + 16'd1;
    end
  end
`else
  assign bus.grant_count_a = 16'h0000;
  assign bus.grant_count_b = 16'h0000;
`endif
endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter: directed checks of round-robin (u0) and fixed-priority (u1) arbiters.
module tb_ram8_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [2:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic [15:0] mem0 [8];
  logic [15:0] mem1 [8];
  int checks = 0;
  int failures = 0;
`ifdef RAM8_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  ram8_arbiter_if i0 ();
  ram8_arbiter_if i1 ();
  ram8_arbiter #(.FIXED_PRIO(1'b0)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
  ram8_arbiter #(.FIXED_PRIO(1'b1)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
  always #5 clk = ~clk;
  assign i0.a_req = a_req;     assign i1.a_req = a_req;
  assign i0.a_we = a_we;       assign i1.a_we = a_we;
  assign i0.a_addr = a_addr;   assign i1.a_addr = a_addr;
  assign i0.a_wdata = a_wdata; assign i1.a_wdata = a_wdata;
  assign i0.b_req = b_req;     assign i1.b_req = b_req;
  assign i0.b_we = b_we;       assign i1.b_we = b_we;
  assign i0.b_addr = b_addr;   assign i1.b_addr = b_addr;
  assign i0.b_wdata = b_wdata; assign i1.b_wdata = b_wdata;
  assign i0.ram_out = mem0[i0.ram_address];
  assign i1.ram_out = mem1[i1.ram_address];
  always @(posedge clk) begin
    if (i0.ram_load) mem0[i0.ram_address] <= i0.ram_in;
    if (i1.ram_load) mem1[i1.ram_address] <= i1.ram_in;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int k = 0; k < 8; k++) begin
      mem0[k] = 16'hA000 + 16'(k);
      mem1[k] = 16'hA000 + 16'(k);
    end
    tick;
    tick;
    check("rst_a_ack", {15'd0, i0.a_ack}, 16'd0);
    check("rst_b_ack", {15'd0, i0.b_ack}, 16'd0);
    check("rst_a_rdata", i0.a_rdata, 16'h0000);
    check("rst_b_rdata", i0.b_rdata, 16'h0000);
    check("rst_load", {15'd0, i0.ram_load}, 16'd0);
    check("rst_addr", {13'd0, i0.ram_address}, 16'd0);
    check("rst_in", i0.ram_in, 16'h0000);
    check("rst_busy", {15'd0, i0.busy}, 16'd0);
    check("rst_cnt_a", i0.grant_count_a, 16'd0);
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 16'hBEEF;
    check("wr_idle_load", {15'd0, i0.ram_load}, 16'd0);
    tick;
    check("wr_serve_load", {15'd0, i0.ram_load}, 16'd1);
    check("wr_serve_addr", {13'd0, i0.ram_address}, 16'd3);
    check("wr_serve_in", i0.ram_in, 16'hBEEF);
    check("wr_serve_busy", {15'd0, i0.busy}, 16'd1);
    check("wr_serve_ack", {15'd0, i0.a_ack}, 16'd0);
    tick;
    check("wr_done_a_ack", {15'd0, i0.a_ack}, 16'd1);
    check("wr_done_b_ack", {15'd0, i0.b_ack}, 16'd0);
    check("wr_done_load", {15'd0, i0.ram_load}, 16'd0);
    check("wr_done_busy", {15'd0, i0.busy}, 16'd1);
    a_req = 1'b0;
    tick;
    check("wr_idle_ack", {15'd0, i0.a_ack}, 16'd0);
    check("wr_idle_busy", {15'd0, i0.busy}, 16'd0);
    check("wr_hold_addr", {13'd0, i0.ram_address}, 16'd3);
    check("wr_hold_in", i0.ram_in, 16'hBEEF);
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd3;
    tick;
    check("rd_serve_load", {15'd0, i0.ram_load}, 16'd0);
    check("rd_serve_addr", {13'd0, i0.ram_address}, 16'd3);
    tick;
    check("rd_done_b_ack", {15'd0, i0.b_ack}, 16'd1);
    check("rd_done_a_ack", {15'd0, i0.a_ack}, 16'd0);
    check("rd_done_b_rdata", i0.b_rdata, 16'hBEEF);
    b_req = 1'b0;
    tick;
    check("rd_held_b_rdata", i0.b_rdata, 16'hBEEF);
    check("rd_idle_b_ack", {15'd0, i0.b_ack}, 16'd0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd2;
    for (int t = 0; t < 4; t++) begin
      tick;
      check($sformatf("tie%0d_rr_addr", t), {13'd0, i0.ram_address}, (t % 2) ? 16'd2 : 16'd1);
      check($sformatf("tie%0d_fp_addr", t), {13'd0, i1.ram_address}, 16'd1);
      tick;
      check($sformatf("tie%0d_rr_a_ack", t), {15'd0, i0.a_ack}, (t % 2) ? 16'd0 : 16'd1);
      check($sformatf("tie%0d_rr_b_ack", t), {15'd0, i0.b_ack}, (t % 2) ? 16'd1 : 16'd0);
      check($sformatf("tie%0d_rr_rdata", t), (t % 2) ? i0.b_rdata : i0.a_rdata, (t % 2) ? 16'hA002 : 16'hA001);
      check($sformatf("tie%0d_fp_a_ack", t), {15'd0, i1.a_ack}, 16'd1);
      check($sformatf("tie%0d_fp_b_ack", t), {15'd0, i1.b_ack}, 16'd0);
      check($sformatf("tie%0d_fp_a_rdata", t), i1.a_rdata, 16'hA001);
      tick;
      check($sformatf("tie%0d_idle_busy", t), {15'd0, i0.busy}, 16'd0);
    end
    a_req = 1'b0;
    tick;
    check("fp_b_addr", {13'd0, i1.ram_address}, 16'd2);
    tick;
    check("fp_b_ack", {15'd0, i1.b_ack}, 16'd1);
    check("fp_b_rdata", i1.b_rdata, 16'hA002);
    check("rr_b_ack", {15'd0, i0.b_ack}, 16'd1);
    b_req = 1'b0;
    tick;
    check("rr_cnt_a", i0.grant_count_a, STATS ? 16'd3 : 16'd0);
    check("rr_cnt_b", i0.grant_count_b, STATS ? 16'd4 : 16'd0);
    check("fp_cnt_a", i1.grant_count_a, STATS ? 16'd5 : 16'd0);
    check("fp_cnt_b", i1.grant_count_b, STATS ? 16'd2 : 16'd0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 16'h1234;
    tick;
    check("mid_serve_load", {15'd0, i0.ram_load}, 16'd1);
    reset = 1'b1;
    a_req = 1'b0;
    #1;
    check("mid_reset_load", {15'd0, i0.ram_load}, 16'd0);
    tick;
    check("mid_reset_a_ack", {15'd0, i0.a_ack}, 16'd0);
    check("mid_reset_busy", {15'd0, i0.busy}, 16'd0);
    check("mid_reset_addr", {13'd0, i0.ram_address}, 16'd0);
    check("mid_reset_cnt_a", i0.grant_count_a, 16'd0);
    reset = 1'b0;
    tick;
    check("post_reset_a_ack", {15'd0, i0.a_ack}, 16'd0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5;
    tick;
    tick;
    check("post_rd_a_ack", {15'd0, i0.a_ack}, 16'd1);
    check("post_rd_a_rdata", i0.a_rdata, 16'hA005);
    check("post_rd_fp_rdata", i1.a_rdata, 16'hA005);
    a_req = 1'b0;
    tick;
    check("post_cnt_a", i0.grant_count_a, STATS ? 16'd1 : 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
